// File: rtl/step_dir_pulse_gen_pkg.sv
// Shared state encoding and default geometry for the step/dir pulse generator.
package step_dir_pulse_gen_pkg;
  localparam int COUNT_W_DEF   = 16;
  localparam int PULSE_W_DEF   = 8;
  localparam int DIR_SETUP_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } state_e;
endpackage

// File: rtl/step_dir_pulse_gen_step_interval_timer.sv
// Loadable down-counter; a phase lasts load_val+1 cycles, expire flags its last cycle.
module step_interval_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] load_val,
  output logic         expire
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start)           cnt_d = load_val;
    else if (cnt_q != '0) cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expire = (cnt_q == '0);
endmodule

// File: rtl/step_dir_pulse_gen.sv
// Step/dir transmitter: timed step pulses with dir setup, halt and move_done.
// Optional STEP_DIR_POSITION_COUNTER_EN adds a signed position counter with clear.
module step_dir_pulse_gen
  import step_dir_pulse_gen_pkg::*;
#(
  parameter int COUNT_W   = COUNT_W_DEF,
  parameter int PULSE_W   = PULSE_W_DEF,
  parameter int DIR_SETUP = DIR_SETUP_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_dir,
  input  logic [COUNT_W-1:0] cmd_steps,
  input  logic [COUNT_W-1:0] cmd_period,
  input  logic               halt,
  output logic               step,
  output logic               dir,
  output logic               busy,
  output logic               move_done,
  output logic [COUNT_W-1:0] steps_remaining
`ifdef STEP_DIR_POSITION_COUNTER_EN
  ,
  input  logic               position_clear,
  output logic signed [31:0] position
`endif
);
  localparam logic [COUNT_W-1:0] PW_M1    = COUNT_W'(PULSE_W - 1);
  localparam logic [COUNT_W-1:0] SETUP_M1 = COUNT_W'(DIR_SETUP - 1);
  localparam logic [COUNT_W-1:0] PMIN     = COUNT_W'(PULSE_W + 1);
  localparam logic [COUNT_W-1:0] PW_P1    = COUNT_W'(PULSE_W + 1);

  state_e             state_q, state_d;
  logic               step_q, step_d, dir_q, dir_d, busy_q, busy_d, done_q, done_d;
  logic               halt_pend_q, halt_pend_d;
  logic [COUNT_W-1:0] rem_q, rem_d, period_q, period_d;
  logic               tmr_start, tmr_expire;
  logic [COUNT_W-1:0] tmr_load;
  logic               accept;

  assign cmd_ready = (state_q == ST_IDLE) && !halt;
  assign accept    = cmd_valid && cmd_ready;

  step_interval_timer #(.W(COUNT_W)) u_tmr (
    .clk      (clk),
    .reset    (reset),
    .start    (tmr_start),
    .load_val (tmr_load),
    .expire   (tmr_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept && cmd_steps != '0) state_d = ST_SETUP;
      ST_SETUP: if (halt) state_d = ST_IDLE;
                else if (tmr_expire) state_d = ST_HIGH;
      // halt in HIGH only takes effect once the pulse has run its full width
      ST_HIGH:  if (tmr_expire) state_d = (halt || halt_pend_q) ? ST_IDLE : ST_LOW;
      ST_LOW:   if (halt) state_d = ST_IDLE;
                else if (tmr_expire) state_d = (rem_q != '0) ? ST_HIGH : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    step_d      = (state_d == ST_HIGH);
    dir_d       = dir_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rem_d       = rem_q;
    period_d    = period_q;
    halt_pend_d = (state_q == ST_HIGH) && (state_d == ST_HIGH) && (halt_pend_q || halt);
    tmr_start   = 1'b0;
    tmr_load    = '0;
    if (state_q == ST_IDLE && accept) begin
      period_d = (cmd_period < PMIN) ? PMIN : cmd_period;
      dir_d    = cmd_dir;
      rem_d    = cmd_steps;
      if (cmd_steps == '0) begin
        done_d = 1'b1;
      end else begin
        busy_d    = 1'b1;
        tmr_start = 1'b1;
        tmr_load  = SETUP_M1;
      end
    end
    if (state_d == ST_HIGH && state_q != ST_HIGH) begin
      rem_d     = rem_q - COUNT_W'(1);
      tmr_start = 1'b1;
      tmr_load  = PW_M1;
    end
    if (state_d == ST_LOW && state_q != ST_LOW) begin
      tmr_start = 1'b1;
      tmr_load  = period_q - PW_P1;
    end
    if (state_q != ST_IDLE && state_d == ST_IDLE) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q      <= 1'b0;
      dir_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rem_q       <= '0;
      period_q    <= PMIN;
      halt_pend_q <= 1'b0;
    end else begin
      step_q      <= step_d;
      dir_q       <= dir_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rem_q       <= rem_d;
      period_q    <= period_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  assign step            = step_q;
  assign dir             = dir_q;
  assign busy            = busy_q;
  assign move_done       = done_q;
  assign steps_remaining = rem_q;

`ifdef STEP_DIR_POSITION_COUNTER_EN
  logic signed [31:0] pos_q, pos_d;

  always_comb begin
    pos_d = pos_q;
    if (state_d == ST_HIGH && state_q != ST_HIGH)
      pos_d = dir_q ? pos_q + 32'sd1 : pos_q - 32'sd1;
    if (position_clear) pos_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pos_q <= '0;
    else       pos_q <= pos_d;
  end

  assign position = pos_q;
`endif
endmodule

// File: doc/step_dir_pulse_gen.md
Name: step_dir_pulse_gen

Overview:
- Transmitter side of the step/dir interface that rapcore's step input consumes.
- Accepts move commands (direction, step count, step period) over a valid/ready handshake.
- Emits timed step pulses with a guaranteed dir setup time.
- Used as a bench/loopback stimulus source and as an on-chip pulse source for a downstream driver.

Parameters:
- COUNT_W, 16, width of the step-count and period fields.
- PULSE_W, 8, step high time in clk cycles (>=1).
- DIR_SETUP, 16, clk cycles dir is held stable before the first step rise of each move (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_dir  in  1  direction for the move.
- cmd_steps  in  COUNT_W  number of step pulses.
- cmd_period  in  COUNT_W  clk cycles between consecutive step rising edges.
- halt  in  1  abort current move.
- step  out  1  step pulse output, active high.
- dir  out  1  direction output.
- busy  out  1  move in progress.
- move_done  out  1  one-cycle pulse when a move ends (normally or by halt).
- steps_remaining  out  COUNT_W  pulses still to be issued.

Behaviour:
- Reset values (async, while reset=1): step=0, dir=0, busy=0, move_done=0, steps_remaining=0, state IDLE.
- All outputs are registered.
- cmd_ready = (state==IDLE) && !halt; combinational from state and halt.
- Command is accepted on the clk edge where cmd_valid && cmd_ready.
- States: IDLE, SETUP, HIGH, LOW.
- IDLE, on accept:
  - Latch period_eff = max(cmd_period, PULSE_W+1).
  - dir <= cmd_dir, steps_remaining <= cmd_steps, busy <= 1.
  - If cmd_steps==0: stay IDLE, busy stays 0, move_done pulses next cycle, no step issued.
  - Otherwise go to SETUP.
- SETUP: lasts exactly DIR_SETUP cycles with step=0, then HIGH.
  - dir is applied on every accepted command, even if unchanged.
- HIGH: step=1 for exactly PULSE_W cycles.
  - steps_remaining decrements by 1 in the first HIGH cycle.
  - Then go to LOW.
- LOW: step=0 for period_eff-PULSE_W cycles.
  - If steps_remaining!=0, go to HIGH, so rise-to-rise spacing equals period_eff.
  - Otherwise go to IDLE, busy<=0, move_done=1 for one cycle.
- Timing, with T0 the accept edge: first step rise visible at T0+DIR_SETUP+1. Rise k (k>=0) at T0+DIR_SETUP+1+k*period_eff.
- Last move: move_done is asserted and busy falls one full period_eff after the last rise. Accept of the next command is possible in that same cycle.
- halt, sampled every cycle:
  - In SETUP or LOW: go to IDLE next edge, step=0, move_done pulse, steps_remaining held at current value.
  - In HIGH: finish the current pulse (no runt pulse), then go to IDLE with move_done. No further rises.
  - In IDLE: cmd_ready low, no accept.
  - halt held high never causes a repeated move_done.
- dir never changes while busy=1.
- The period counter is COUNT_W bits, loaded and compared against period_eff-1. No wrap occurs because period_eff <= 2^COUNT_W-1.
- Reset mid-move: immediate async return to reset values. No move_done is issued.

Optional Feature:
- Macro: STEP_DIR_POSITION_COUNTER_EN.
- When defined:
  - Adds output position, signed, 32 bits, reset 0.
  - Increments on each step rise when dir=1 and decrements when dir=0, in the same cycle step goes high.
  - Wraps in two's complement.
  - Adds input position_clear (synchronous clear to 0). A clear that coincides with a step rise makes position 0; the count for that rise is discarded.
- When undefined: neither port exists and there is no counter logic.

Decomposition:
- Shared package: state encoding constants (IDLE/SETUP/HIGH/LOW), default COUNT_W, PULSE_W, DIR_SETUP.
- One sub-module, step_interval_timer:
  - Loadable down-counter with load value, start and expire outputs.
  - Reused for the SETUP, HIGH and LOW durations.

Test Plan:
- Reset asserted mid-HIGH -> step=0, busy=0, steps_remaining=0 immediately. No move_done.
- steps=3, period=20, dir=1, defaults, accept at T0:
  - dir=1 at T0+1.
  - Step rises at T0+17, T0+37, T0+57, each 8 cycles high.
  - move_done at T0+77. steps_remaining sequence 3,2,1,0.
- period=4 (<PULSE_W+1) with steps=2 -> rises spaced 9 cycles, low time 1 cycle.
- steps=0 accepted -> no step edge, move_done one cycle after accept, busy never high.
- halt raised 3 cycles into HIGH of pulse 2 of a 5-step move:
  - Pulse completes its full 8 cycles, then IDLE with move_done.
  - steps_remaining=3. cmd_ready low until halt drops.
- STEP_DIR_POSITION_COUNTER_EN: 4 steps dir=1 then 6 steps dir=0 -> position 4 then -2. position_clear coincident with a rise -> 0.
